// File: rtl/ddr_in_deser.sv
// Purpose: DDR input capture and deserialiser for the HyperRAM read path; packs BEATS DDR beats per lane group into one word.
// Latency: pair {r(t), f(t)} is visible after rise t+1; the word strobe follows one clk after the pair that completes it.
// Backpressure: none; dout_valid is a one-cycle strobe and the downstream read FIFO must always accept it.
//
// Ports:
//   clk, reset        capture clock (data on both edges), asynchronous active-high reset
//   din               WIDTH DDR pad lanes
//   capture_en        read window, qualifies the pair captured in the same cycle
//   fal_first         beat pairing phase, sampled when capture_en rises
//   dout              assembled word, beat 0 in the LSBs; held between strobes
//   dout_valid        one-cycle word strobe
//   dout_last         last word of the window (only with dout_valid)
//   dout_partial      word incomplete, unfilled beats zero (only with dout_valid)
//   word_cnt          words emitted since capture_en rose, saturating
module ddr_in_deser #(
  parameter int WIDTH = 8,
  parameter int BEATS = 4,   // even, at least 2
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       din,
  input  logic                   capture_en,
  input  logic                   fal_first,
  output logic [WIDTH*BEATS-1:0] dout,
  output logic                   dout_valid,
  output logic                   dout_last,
  output logic                   dout_partial,
  output logic [CNT_W-1:0]       word_cnt
);

  localparam int PAIRS  = BEATS / 2;
  localparam int PTR_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int PAIR_W = 2 * WIDTH;
  localparam int WORD_W = WIDTH * BEATS;

  // ---------------------------------------------------------------------------
  // DDR input cells, one per lane (vectorised), same-edge-pipelined:
  // both halves of cycle t appear together on rise_q/fall_q after rise t+1.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rise_d, rise_q;
  logic [WIDTH-1:0] fall_d, fall_q;

`ifdef LINT
  always_comb begin
    rise_d = din;
    fall_d = din;
  end
`else
  logic [WIDTH-1:0] rise_cap_d, rise_cap_q;
  logic [WIDTH-1:0] fall_cap_d, fall_cap_q;

  always_comb begin
    rise_cap_d = din;
    fall_cap_d = din;
    rise_d     = rise_cap_q;
    fall_d     = fall_cap_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rise_cap_q <= '0;
    else       rise_cap_q <= rise_cap_d;
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) fall_cap_q <= '0;
    else       fall_cap_q <= fall_cap_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Framing and assembly
  // ---------------------------------------------------------------------------
  logic              en_d_d, en_d_q;
  logic              mode_d, mode_q;
  logic [WIDTH-1:0]  hold_d, hold_q;
  logic              hold_vld_d, hold_vld_q;
  logic [PTR_W-1:0]  beat_cnt_d, beat_cnt_q;
  logic [WORD_W-1:0] word_d, word_q;
  logic [WORD_W-1:0] dout_d, dout_q;
  logic              dout_valid_d, dout_valid_q;
  logic              dout_last_d, dout_last_q;
  logic              dout_partial_d, dout_partial_q;
  logic [CNT_W-1:0]  word_cnt_d, word_cnt_q;

  logic              en_rise, win_end, accept, wrap, emit;
  logic [WIDTH-1:0]  pair_lo, pair_hi;
  logic [PTR_W-1:0]  beat_cnt_nxt;
  logic [WORD_W-1:0] word_nxt;

  always_comb begin
    // capture_en is already one cycle ahead of en_d, so the window edges are
    // known in the cycle that processes the last (or first) pair.
    en_rise = capture_en & ~en_d_q;
    win_end = en_d_q & ~capture_en;

    // Mode 1 pairs the previous fall with the current rise; the first cycle
    // of the window only primes the holding register.
    pair_lo = mode_q ? hold_q : rise_q;
    pair_hi = mode_q ? rise_q : fall_q;
    accept  = en_d_q & (~mode_q | hold_vld_q);
    wrap    = accept && (beat_cnt_q == PTR_W'(PAIRS - 1));

    word_nxt = word_q;
    if (accept) begin
      word_nxt[int'(beat_cnt_q) * PAIR_W +: PAIR_W] = {pair_hi, pair_lo};
    end

    beat_cnt_nxt = beat_cnt_q;
    if (accept) begin
      beat_cnt_nxt = wrap ? '0 : beat_cnt_q + PTR_W'(1);
    end

    emit = wrap | (win_end & (beat_cnt_nxt != '0));

    en_d_d         = capture_en;
    mode_d         = en_rise ? fal_first : mode_q;
    hold_d         = (en_d_q & ~win_end) ? fall_q : '0;
    hold_vld_d     = en_d_q & ~win_end;
    beat_cnt_d     = win_end ? '0 : beat_cnt_nxt;
    // Assembly buffer restarts from zero so a partial word is zero-padded.
    word_d         = (emit | win_end) ? '0 : word_nxt;
    dout_d         = dout_q;
    dout_valid_d   = 1'b0;
    dout_last_d    = 1'b0;
    dout_partial_d = 1'b0;
    word_cnt_d     = word_cnt_q;

    if (emit) begin
      dout_d         = word_nxt;
      dout_valid_d   = 1'b1;
      dout_last_d    = win_end;
      dout_partial_d = ~wrap;
    end

    // en_rise needs en_d low and emit needs en_d high, so they never collide.
    if (en_rise) begin
      word_cnt_d = '0;
    end else if (emit && (word_cnt_q != {CNT_W{1'b1}})) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_d_q         <= 1'b0;
      mode_q         <= 1'b0;
      hold_q         <= '0;
      hold_vld_q     <= 1'b0;
      beat_cnt_q     <= '0;
      word_q         <= '0;
      dout_q         <= '0;
      dout_valid_q   <= 1'b0;
      dout_last_q    <= 1'b0;
      dout_partial_q <= 1'b0;
      word_cnt_q     <= '0;
    end else begin
      en_d_q         <= en_d_d;
      mode_q         <= mode_d;
      hold_q         <= hold_d;
      hold_vld_q     <= hold_vld_d;
      beat_cnt_q     <= beat_cnt_d;
      word_q         <= word_d;
      dout_q         <= dout_d;
      dout_valid_q   <= dout_valid_d;
      dout_last_q    <= dout_last_d;
      dout_partial_q <= dout_partial_d;
      word_cnt_q     <= word_cnt_d;
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign dout_last    = dout_last_q;
  assign dout_partial = dout_partial_q;
  assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_ddr_in_deser.sv
// Purpose: directed self-checking bench for ddr_in_deser (WIDTH=8, BEATS=4).
// Latency: inputs change 1ns after clock edges; outputs sampled on the falling edge.
// Backpressure: not applicable; every strobe is recorded by a monitor.
module tb_ddr_in_deser;

  logic        clk;
  logic        reset;
  logic [7:0]  din;
  logic        capture_en;
  logic        fal_first;

  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_last;
  logic        dout_partial;
  logic [15:0] word_cnt;

  logic [31:0] sat_dout;
  logic        sat_valid;
  logic        sat_last;
  logic        sat_partial;
  logic [3:0]  sat_cnt;

  ddr_in_deser #(.WIDTH(8), .BEATS(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .din(din), .capture_en(capture_en), .fal_first(fal_first),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
    .dout_partial(dout_partial), .word_cnt(word_cnt)
  );

  ddr_in_deser #(.WIDTH(8), .BEATS(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .din(din), .capture_en(capture_en), .fal_first(fal_first),
    .dout(sat_dout), .dout_valid(sat_valid), .dout_last(sat_last),
    .dout_partial(sat_partial), .word_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
    logic        part;
    logic [15:0] cnt;
  } strobe_t;

  strobe_t sq[$];
  int      n_checks = 0;
  int      n_err = 0;
  int      bad_idle = 0;
  int      sat_strobes = 0;

  always @(negedge clk) begin
    if (dout_valid) sq.push_back({dout, dout_last, dout_partial, word_cnt});
    if (!dout_valid && (dout_last || dout_partial)) bad_idle++;
    if (sat_valid) sat_strobes++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_strobe(input string tag, input int idx, input logic [31:0] dat,
                            input logic last, input logic part, input logic [15:0] cnt);
    chk({tag, "_present"}, 64'(sq.size() > idx), 64'(1));
    if (sq.size() > idx) begin
      chk({tag, "_dout"},    64'(sq[idx].dat),  64'(dat));
      chk({tag, "_last"},    64'(sq[idx].last), 64'(last));
      chk({tag, "_partial"}, 64'(sq[idx].part), 64'(part));
      chk({tag, "_cnt"},     64'(sq[idx].cnt),  64'(cnt));
    end
  endtask

  // One clk cycle: rv is sampled at the rising edge, fv at the falling edge;
  // en qualifies this cycle's pair. Called 1ns after a falling edge.
  task automatic step(input logic en, input logic [7:0] rv, input logic [7:0] fv);
    din = rv;
    @(posedge clk);
    #1;
    din        = fv;
    capture_en = en;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    reset      = 1'b1;
    din        = 8'h00;
    capture_en = 1'b0;
    fal_first  = 1'b0;

    #2;
    chk("rst_dout",    64'(dout),         64'(0));
    chk("rst_valid",   64'(dout_valid),   64'(0));
    chk("rst_last",    64'(dout_last),    64'(0));
    chk("rst_partial", 64'(dout_partial), 64'(0));
    chk("rst_cnt",     64'(word_cnt),     64'(0));

    @(negedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Mode 0, two full words.
    sq.delete();
    step(1'b1, 8'h00, 8'h01);
    step(1'b1, 8'h02, 8'h03);
    step(1'b1, 8'h04, 8'h05);
    step(1'b1, 8'h06, 8'h07);
    idle(3);
    chk("m0_n", 64'(sq.size()), 64'(2));
    exp_strobe("m0_w0", 0, 32'h03020100, 1'b0, 1'b0, 16'd1);
    exp_strobe("m0_w1", 1, 32'h07060504, 1'b1, 1'b0, 16'd2);
    chk("m0_hold_dout", 64'(dout), 64'h07060504);

    // Mode 1, data shifted half a cycle; first window cycle only primes.
    fal_first = 1'b1;
    sq.delete();
    step(1'b1, 8'hEE, 8'h00);
    step(1'b1, 8'h01, 8'h02);
    step(1'b1, 8'h03, 8'h04);
    step(1'b1, 8'h05, 8'h06);
    step(1'b0, 8'h07, 8'h00);
    idle(3);
    fal_first = 1'b0;
    chk("m1_n", 64'(sq.size()), 64'(2));
    exp_strobe("m1_w0", 0, 32'h03020100, 1'b0, 1'b0, 16'd1);
    exp_strobe("m1_w1", 1, 32'h00000504, 1'b1, 1'b1, 16'd2);

    // Three-cycle window: full word then zero-padded partial.
    sq.delete();
    step(1'b1, 8'h10, 8'h11);
    step(1'b1, 8'h12, 8'h13);
    step(1'b1, 8'h14, 8'h15);
    idle(3);
    chk("part_n", 64'(sq.size()), 64'(2));
    exp_strobe("part_w0", 0, 32'h13121110, 1'b0, 1'b0, 16'd1);
    exp_strobe("part_w1", 1, 32'h00001514, 1'b1, 1'b1, 16'd2);

    // Two 2-cycle windows separated by a single low cycle.
    sq.delete();
    step(1'b1, 8'h40, 8'h41);
    step(1'b1, 8'h42, 8'h43);
    step(1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h50, 8'h51);
    step(1'b1, 8'h52, 8'h53);
    idle(4);
    chk("reopen_n", 64'(sq.size()), 64'(2));
    exp_strobe("reopen_w0", 0, 32'h43424140, 1'b1, 1'b0, 16'd1);
    exp_strobe("reopen_w1", 1, 32'h53525150, 1'b1, 1'b0, 16'd1);

    // Asynchronous reset after one accepted pair.
    sq.delete();
    step(1'b1, 8'h20, 8'h21);
    step(1'b1, 8'h22, 8'h23);
    @(posedge clk);
    #3;
    capture_en = 1'b0;
    din        = 8'h00;
    reset      = 1'b1;
    #1;
    chk("arst_dout",    64'(dout),         64'(0));
    chk("arst_valid",   64'(dout_valid),   64'(0));
    chk("arst_last",    64'(dout_last),    64'(0));
    chk("arst_partial", 64'(dout_partial), 64'(0));
    chk("arst_cnt",     64'(word_cnt),     64'(0));
    sq.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
    idle(3);
    chk("arst_no_strobe", 64'(sq.size()), 64'(0));
    step(1'b1, 8'h30, 8'h31);
    step(1'b1, 8'h32, 8'h33);
    idle(3);
    chk("arst_next_n", 64'(sq.size()), 64'(1));
    exp_strobe("arst_next", 0, 32'h33323130, 1'b1, 1'b0, 16'd1);

    // Long window of 20 words: 16-bit counter reaches 20, 4-bit saturates at 15.
    sq.delete();
    sat_strobes = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 8'(2 * i), 8'(2 * i + 1));
    idle(4);
    chk("sat_n",        64'(sq.size()),  64'(20));
    chk("sat_strobes",  64'(sat_strobes), 64'(20));
    chk("sat_cnt4",     64'(sat_cnt),    64'(15));
    chk("sat_cnt16",    64'(word_cnt),   64'(20));
    exp_strobe("sat_w0",  0,  32'h03020100, 1'b0, 1'b0, 16'd1);
    exp_strobe("sat_w19", 19, 32'h4F4E4D4C, 1'b1, 1'b0, 16'd20);
    chk("sat_hold_dout", 64'(dout), 64'h4F4E4D4C);

    chk("idle_flags", 64'(bad_idle), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr_in_deser.md
Name: ddr_in_deser

Overview:
- Parametrised DDR input capture and deserialiser for the HyperRAM read path (DQ and RWDS lanes).
- Captures WIDTH DDR input lanes with one DDR input cell per lane, configured for same-edge-pipelined output.
- Re-pairs beats for a selectable half-cycle phase and assembles BEATS consecutive DDR beats into one wide word, with framing (valid/last/partial) and a word counter.
- Sits between the pad-level DDR input cells and the read-data FIFO of the HyperRAM controller.

Parameters:
- WIDTH, 8, number of DDR input lanes.
- BEATS, 4, DDR beats (half-cycles) per output word; must be even, minimum 2.
- CNT_W, 16, width of the word counter.

Ports:
- clk  input  1  capture clock; DDR data is aligned to both of its edges.
- reset  input  1  asynchronous, active-high reset.
- din  input  WIDTH  DDR pad data.
- capture_en  input  1  read window, synchronous to clk; qualifies pairs captured in the same cycle.
- fal_first  input  1  0: a beat pair is {rise t, fall t}; 1: a beat pair is {fall t, rise t+1}. Sampled only when capture_en rises.
- dout  output  WIDTH*BEATS  assembled word; beat 0 occupies the LSBs.
- dout_valid  output  1  one-cycle strobe that dout is valid.
- dout_last  output  1  with dout_valid: last word of the window.
- dout_partial  output  1  with dout_valid: word is incomplete; unfilled beats are zero.
- word_cnt  output  CNT_W  words emitted since capture_en rose; saturates at all-ones.

Behaviour:
- Capture stage
  - Per lane: r(t) = din at rise t, f(t) = din at fall t.
  - The pair {r(t), f(t)} is presented to the clk-domain logic after rise t+1 (one cycle of cell latency).
  - capture_en is delayed by 1 cycle (en_d) to align with the cell outputs.
  - Under LINT, cell outputs r and f both equal din, registered.
- Phase select
  - fal_first is latched into a mode flop on the cycle capture_en goes 0->1.
  - Mode 0: beat pair = {r(t), f(t)}.
  - Mode 1: beat pair = {f(t-1), r(t)}, using a one-cycle holding register for f.
  - In mode 1, the first en_d cycle only loads the holding register; no pair is accepted.
- Assembly
  - Two beats per accepted cycle; first beat to the lower slot.
  - A beat counter 0..BEATS/2-1 advances per accepted pair.
  - When the counter wraps, the full word is registered to dout and dout_valid=1 the next cycle.
  - Latency from rise t+1 (pair visible) to the dout_valid cycle = 1 clk.
- Window end (en_d 1->0)
  - With the counter at 0: the most recent full word, if emitted in the same cycle, carries dout_last=1. Otherwise no extra strobe; the window is simply closed.
  - With the counter nonzero: emit the partial word, zero-padded, with dout_valid=1, dout_last=1, dout_partial=1.
  - On window end, the counter and holding register clear.
- Re-open
  - capture_en may re-rise on the cycle after it falls.
  - word_cnt clears to 0 on capture_en 0->1 and increments on each dout_valid, including partial words; it saturates at all-ones.
- Outputs
  - dout holds its value between strobes.
  - dout_last and dout_partial are 0 whenever dout_valid=0.
- Reset (asynchronous, any time, including mid-window)
  - dout=0, dout_valid=0, dout_last=0, dout_partial=0, word_cnt=0.
  - Beat counter=0, mode=0, en_d=0, holding register=0.
  - No strobe is emitted for the aborted partial word.
  - After reset release, the first window behaves as from power-up.
- Simultaneous events
  - Counter wrap and window end in the same cycle: a single strobe, with dout_last=1 and dout_partial=0.

Test Plan:
- WIDTH=8, BEATS=4, mode 0, capture_en high for 4 cycles, din beats 0x00..0x07 -> two strobes: dout=0x03020100, then 0x07060504 with last=1; word_cnt=2.
- Same stimulus with fal_first=1 and beats offset by a half-cycle -> first word 0x03020100 is correctly re-paired; the first en_d cycle produces no strobe.
- capture_en high for 3 cycles, beats 0x10..0x15 -> 0x13121110 then 0x00001514 with partial=1, last=1.
- Assert reset mid-window after 1 accepted pair -> all outputs 0 immediately (async); no strobe after release; the next window's first word is correct.
- CNT_W=4, window of 20 words -> word_cnt stops at 15; dout_valid continues for all 20 words.
- capture_en falls for exactly 1 cycle between two 2-cycle windows -> each window yields one word with last=1; word_cnt restarts at 1.
